// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multi-cycle sequencer for a MIPS-style datapath. Owns the PC and steps each
// instruction through FETCH / DECODE / EXEC / MEM / WB, producing the per-state
// strobes and datapath selects. A single memory port is shared between
// instruction fetch and data access; every memory request is held until the
// memory answers with mem_ready.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//   CNT_W       width of the retired-instruction counter (wraps modulo 2^CNT_W)
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   opcode      in   6      instr[31:26] from the instruction register
//   imm         in   16     instr[15:0], branch word offset
//   alu_zero    in   1      ALU zero flag, meaningful in EXEC
//   mem_ready   in   1      memory port completes the current request
//   pc          out  32     current PC (already +4 once FETCH completes)
//   ir_we       out  1      load instruction register
//   mem_rd      out  1      memory read request (fetch or lw)
//   mem_wr      out  1      memory write request (sw)
//   i_or_d      out  1      0 = fetch address, 1 = data address
//   alu_op      out  2      00 add, 01 sub, 10 funct-decoded
//   alusrc      out  1      1 = sign-extended immediate on ALU B
//   regdest     out  1      1 = rd, 0 = rt
//   mem_to_reg  out  1      1 = write back from memory
//   reg_we      out  1      register-file write strobe
//   illegal_op  out  1      one-cycle pulse on an undefined opcode
//   halted      out  1      controller parked in HALT
//   state       out  3      FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
//   retired     out  CNT_W  completed-instruction count
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [15:0]      imm,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic             ir_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             i_or_d,
  output logic [1:0]       alu_op,
  output logic             alusrc,
  output logic             regdest,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             illegal_op,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_R    = 3'd1,
    C_LW   = 3'd2,
    C_SW   = 3'd3,
    C_BEQ  = 3'd4,
    C_ADDI = 3'd5,
    C_HALT = 3'd6,
    C_ILL  = 3'd7
  } class_t;

  state_t           r_state;
  state_t           w_state_nxt;
  class_t           r_class;
  class_t           w_dec_class;
  logic [31:0]      r_pc;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_br_take;
  logic [31:0]      w_pc_inc;
  logic [31:0]      w_br_off;

  assign pc      = r_pc;
  assign state   = r_state;
  assign retired = r_retired;

  // Word offset, sign-extended and scaled to bytes; added to the PC that has
  // already been advanced past the branch itself.
  assign w_br_off  = {{14{imm[15]}}, imm, 2'b00};
  assign w_pc_inc  = r_pc + 32'd4;
  assign w_br_take = (r_state == S_EXEC) && (r_class == C_BEQ) && alu_zero;

  always_comb begin
    case (opcode)
      6'b000000: w_dec_class = C_R;
      6'b100011: w_dec_class = C_LW;
      6'b101011: w_dec_class = C_SW;
      6'b000100: w_dec_class = C_BEQ;
      6'b001000: w_dec_class = C_ADDI;
      6'b111111: w_dec_class = C_HALT;
      default:   w_dec_class = C_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_class   <= C_NOP;
      r_pc      <= RESET_PC;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DECODE) begin
        r_class <= w_dec_class;
      end
      if ((r_state == S_FETCH) && mem_ready) begin
        r_pc <= w_pc_inc;
      end else if (w_br_take) begin
        r_pc <= r_pc + w_br_off;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    ir_we       = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    i_or_d      = 1'b0;
    alu_op      = 2'b00;
    alusrc      = 1'b0;
    regdest     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_we      = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_we       = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end

      // The class register is only written at the end of this cycle, so the
      // branch decision here uses the live decode of the opcode.
      S_DECODE: begin
        case (w_dec_class)
          C_ILL: begin
            illegal_op  = 1'b1;
            w_state_nxt = S_FETCH;
          end
          C_HALT:  w_state_nxt = S_HALT;
          default: w_state_nxt = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (r_class)
          C_R: begin
            alu_op      = 2'b10;
            w_state_nxt = S_WB;
          end
          C_BEQ: begin
            alu_op      = 2'b01;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
          C_LW, C_SW: begin
            alusrc      = 1'b1;
            w_state_nxt = S_MEM;
          end
          C_ADDI: begin
            alusrc      = 1'b1;
            w_state_nxt = S_WB;
          end
          default: w_state_nxt = S_FETCH;
        endcase
      end

      S_MEM: begin
        i_or_d = 1'b1;
        alusrc = 1'b1;
        mem_rd = (r_class == C_LW);
        mem_wr = (r_class == C_SW);
        if (mem_ready) begin
          if (r_class == C_LW) begin
            w_state_nxt = S_WB;
          end else begin
            w_retire    = (r_class == C_SW);
            w_state_nxt = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_we      = 1'b1;
        regdest     = (r_class == C_R);
        mem_to_reg  = (r_class == C_LW);
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: w_state_nxt = S_FETCH;
    endcase

    // While reset is held the controller is in FETCH, but nothing may be
    // requested of the datapath or memory until reset is released.
    if (!rst_n) begin
      w_retire   = 1'b0;
      ir_we      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      i_or_d     = 1'b0;
      alu_op     = 2'b00;
      alusrc     = 1'b0;
      regdest    = 1'b0;
      mem_to_reg = 1'b0;
      reg_we     = 1'b0;
      illegal_op = 1'b0;
      halted     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each stimulus cycle drives the inputs
// and queues the hand-computed state, pc, strobe word and retired count for
// that cycle; a separate monitor pops and compares on the falling edge.
// Strobe word bit order:
//   {ir_we, mem_rd, mem_wr, i_or_d, alu_op[1:0], alusrc, regdest,
//    mem_to_reg, reg_we, illegal_op, halted}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_ILL  = 6'b111110;

  localparam logic [11:0] SB_0   = 12'h000; // idle / DECODE
  localparam logic [11:0] SB_FW  = 12'h400; // FETCH waiting
  localparam logic [11:0] SB_F   = 12'hC00; // FETCH completing
  localparam logic [11:0] SB_ILL = 12'h002; // DECODE of illegal opcode
  localparam logic [11:0] SB_ER  = 12'h080; // EXEC R-type
  localparam logic [11:0] SB_EB  = 12'h040; // EXEC BEQ
  localparam logic [11:0] SB_EI  = 12'h020; // EXEC LW/SW/ADDI
  localparam logic [11:0] SB_MLW = 12'h520; // MEM lw
  localparam logic [11:0] SB_MSW = 12'h320; // MEM sw
  localparam logic [11:0] SB_WR  = 12'h014; // WB R-type
  localparam logic [11:0] SB_WLW = 12'h00C; // WB lw
  localparam logic [11:0] SB_WAD = 12'h004; // WB addi
  localparam logic [11:0] SB_H   = 12'h001; // HALT

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic        alu_zero;
  logic        mem_ready;
  logic [31:0] pc;
  logic        ir_we, mem_rd, mem_wr, i_or_d;
  logic [1:0]  alu_op;
  logic        alusrc, regdest, mem_to_reg, reg_we, illegal_op, halted;
  logic [2:0]  state;
  logic [15:0] retired;
  logic [11:0] w_sb;

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .RESET_PC (RST_PC),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .imm        (imm),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .pc         (pc),
    .ir_we      (ir_we),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .i_or_d     (i_or_d),
    .alu_op     (alu_op),
    .alusrc     (alusrc),
    .regdest    (regdest),
    .mem_to_reg (mem_to_reg),
    .reg_we     (reg_we),
    .illegal_op (illegal_op),
    .halted     (halted),
    .state      (state),
    .retired    (retired)
  );

  assign w_sb = {ir_we, mem_rd, mem_wr, i_or_d, alu_op, alusrc, regdest,
                 mem_to_reg, reg_we, illegal_op, halted};

  typedef struct {
    logic [2:0]  st;
    logic [31:0] pc;
    logic [11:0] sb;
    logic [15:0] ret;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_push = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  // One cycle of stimulus: drive inputs shortly after the rising edge and
  // queue what the DUT should show for the rest of that cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic [15:0] im,
                     input logic az, input logic rdy, input logic [2:0] st,
                     input logic [31:0] p, input logic [11:0] sb, input logic [15:0] rt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n     = rst;
    opcode    = op;
    imm       = im;
    alu_zero  = az;
    mem_ready = rdy;
    e.st  = st;
    e.pc  = p;
    e.sb  = sb;
    e.ret = rt;
    e.id  = n_push;
    n_push++;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (state !== e.st || pc !== e.pc || w_sb !== e.sb || retired !== e.ret) begin
        n_bad++;
        $display("FAIL vec%0d: got state=%0d pc=%h strobes=%h retired=%0d, want state=%0d pc=%h strobes=%h retired=%0d",
                 e.id, state, pc, w_sb, retired, e.st, e.pc, e.sb, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = OP_R;
    imm       = 16'h0000;
    alu_zero  = 1'b0;
    mem_ready = 1'b0;

    // Reset state: FETCH, pc at reset value, no strobes.
    cyc(0, OP_R,    16'h0000, 0, 1, 3'd0, 32'h0000_0100, SB_0,   16'd0);

    // BEQ at 0x100, offset -1, taken: pc returns to 0x100.
    cyc(1, OP_BEQ,  16'hFFFF, 0, 1, 3'd0, 32'h0000_0100, SB_F,   16'd0);
    cyc(1, OP_BEQ,  16'hFFFF, 0, 1, 3'd1, 32'h0000_0104, SB_0,   16'd0);
    cyc(1, OP_BEQ,  16'hFFFF, 1, 1, 3'd2, 32'h0000_0104, SB_EB,  16'd0);
    // Same BEQ, not taken: pc stays at 0x104.
    cyc(1, OP_BEQ,  16'hFFFF, 0, 1, 3'd0, 32'h0000_0100, SB_F,   16'd1);
    cyc(1, OP_BEQ,  16'hFFFF, 0, 1, 3'd1, 32'h0000_0104, SB_0,   16'd1);
    cyc(1, OP_BEQ,  16'hFFFF, 0, 1, 3'd2, 32'h0000_0104, SB_EB,  16'd1);

    // R-type: 0,1,2,4.
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd0, 32'h0000_0104, SB_F,   16'd2);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd1, 32'h0000_0108, SB_0,   16'd2);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd2, 32'h0000_0108, SB_ER,  16'd2);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd4, 32'h0000_0108, SB_WR,  16'd2);

    // ADDI: 0,1,2,4 with alusrc and plain writeback.
    cyc(1, OP_ADDI, 16'h0005, 0, 1, 3'd0, 32'h0000_0108, SB_F,   16'd3);
    cyc(1, OP_ADDI, 16'h0005, 0, 1, 3'd1, 32'h0000_010C, SB_0,   16'd3);
    cyc(1, OP_ADDI, 16'h0005, 0, 1, 3'd2, 32'h0000_010C, SB_EI,  16'd3);
    cyc(1, OP_ADDI, 16'h0005, 0, 1, 3'd4, 32'h0000_010C, SB_WAD, 16'd3);

    // LW: one fetch wait, then two MEM waits; mem_rd held through MEM.
    cyc(1, OP_LW,   16'h0010, 0, 0, 3'd0, 32'h0000_010C, SB_FW,  16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 1, 3'd0, 32'h0000_010C, SB_F,   16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 1, 3'd1, 32'h0000_0110, SB_0,   16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 1, 3'd2, 32'h0000_0110, SB_EI,  16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 0, 3'd3, 32'h0000_0110, SB_MLW, 16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 0, 3'd3, 32'h0000_0110, SB_MLW, 16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 1, 3'd3, 32'h0000_0110, SB_MLW, 16'd4);
    cyc(1, OP_LW,   16'h0010, 0, 1, 3'd4, 32'h0000_0110, SB_WLW, 16'd4);

    // SW with ready memory: retires from MEM.
    cyc(1, OP_SW,   16'h0020, 0, 1, 3'd0, 32'h0000_0110, SB_F,   16'd5);
    cyc(1, OP_SW,   16'h0020, 0, 1, 3'd1, 32'h0000_0114, SB_0,   16'd5);
    cyc(1, OP_SW,   16'h0020, 0, 1, 3'd2, 32'h0000_0114, SB_EI,  16'd5);
    cyc(1, OP_SW,   16'h0020, 0, 1, 3'd3, 32'h0000_0114, SB_MSW, 16'd5);

    // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
    cyc(1, OP_ILL,  16'h0000, 0, 1, 3'd0, 32'h0000_0114, SB_F,   16'd6);
    cyc(1, OP_ILL,  16'h0000, 0, 1, 3'd1, 32'h0000_0118, SB_ILL, 16'd6);

    // BEQ with most negative offset: 0x11C + 0xFFFE0000 wraps to 0xFFFE011C.
    cyc(1, OP_BEQ,  16'h8000, 0, 1, 3'd0, 32'h0000_0118, SB_F,   16'd6);
    cyc(1, OP_BEQ,  16'h8000, 0, 1, 3'd1, 32'h0000_011C, SB_0,   16'd6);
    cyc(1, OP_BEQ,  16'h8000, 1, 1, 3'd2, 32'h0000_011C, SB_EB,  16'd6);

    // HALT: parked with only halted set, whatever the inputs do.
    cyc(1, OP_HALT, 16'h0000, 0, 1, 3'd0, 32'hFFFE_011C, SB_F,   16'd7);
    cyc(1, OP_HALT, 16'h0000, 0, 1, 3'd1, 32'hFFFE_0120, SB_0,   16'd7);
    for (int i = 0; i < 20; i++) begin
      cyc(1, OP_HALT, 16'h0000, i[0], ~i[0], 3'd5, 32'hFFFE_0120, SB_H, 16'd7);
    end

    // Reset out of HALT.
    cyc(0, OP_R,    16'h0000, 0, 1, 3'd0, 32'h0000_0100, SB_0,   16'd0);

    // R-type to make retired non-zero, then SW stalled in MEM.
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd0, 32'h0000_0100, SB_F,   16'd0);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd1, 32'h0000_0104, SB_0,   16'd0);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd2, 32'h0000_0104, SB_ER,  16'd0);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd4, 32'h0000_0104, SB_WR,  16'd0);
    cyc(1, OP_SW,   16'h0000, 0, 1, 3'd0, 32'h0000_0104, SB_F,   16'd1);
    cyc(1, OP_SW,   16'h0000, 0, 1, 3'd1, 32'h0000_0108, SB_0,   16'd1);
    cyc(1, OP_SW,   16'h0000, 0, 1, 3'd2, 32'h0000_0108, SB_EI,  16'd1);
    cyc(1, OP_SW,   16'h0000, 0, 0, 3'd3, 32'h0000_0108, SB_MSW, 16'd1);
    // Reset asserted mid-cycle while the write is pending: takes effect
    // before the next clock edge.
    cyc(0, OP_SW,   16'h0000, 0, 0, 3'd0, 32'h0000_0100, SB_0,   16'd0);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd0, 32'h0000_0100, SB_F,   16'd0);
    cyc(1, OP_R,    16'h0000, 0, 1, 3'd1, 32'h0000_0104, SB_0,   16'd0);

    @(negedge clk);
    #1;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
